// File: rtl/set_bit_sequencer.sv
// -----------------------------------------------------------------------------
// set_bit_sequencer
//
// Turns a request vector into a stream of set-bit indices, starting with the
// lowest. An accepted vector is held in `pending`. Each accepted output beat
// reports the index of the lowest set bit still pending, then clears that bit.
// When the last bit has been delivered the block can take a new vector in the
// same cycle, so consecutive vectors stream with no gap between them.
//
// Optional feature (compile-time macro):
//   SET_BIT_SEQUENCER_NULL_EN - an all-zero vector produces one "null" beat
//                               (out_index=0, out_last=1, out_null=1). When the
//                               macro is undefined, zero vectors are dropped
//                               and out_null is tied to 0.
//
// Parameters:
//   INPUTBITWIDTH   width of the request vector (>= 2)
//   OUTPUTBITWIDTH  index width, derived as $clog2(INPUTBITWIDTH); leave as is
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort; discards the pending vector
//   in_valid   in_data is presented
//   in_ready   block can accept a vector this cycle
//   in_data    request vector
//   out_valid  out_index is valid
//   out_ready  consumer accepts the current beat
//   out_index  index of the lowest set bit still pending
//   out_last   current beat is the final bit of the vector
//   out_null   current beat reports an all-zero vector
//   busy       a vector is pending
// -----------------------------------------------------------------------------
module set_bit_sequencer #(
  parameter int INPUTBITWIDTH  = 16,
  parameter int OUTPUTBITWIDTH = $clog2(INPUTBITWIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INPUTBITWIDTH-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUTPUTBITWIDTH-1:0] out_index,
  output logic                      out_last,
  output logic                      out_null,
  output logic                      busy
);

  localparam logic [INPUTBITWIDTH-1:0] ONE = INPUTBITWIDTH'(1);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
`ifdef SET_BIT_SEQUENCER_NULL_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    NULL_BEAT = 2'd2
  } state_t;
  // Where an accepted all-zero vector goes.
  localparam state_t EMPTY_STATE = NULL_BEAT;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
  localparam state_t EMPTY_STATE = IDLE;
`endif

  state_t                     state_reg;
  state_t                     state_next;
  logic [INPUTBITWIDTH-1:0]   pending_reg;
  logic [INPUTBITWIDTH-1:0]   pending_next;

  // ---------------------------------------------------------------------------
  // Datapath: lowest-set-bit isolation and its binary index
  // ---------------------------------------------------------------------------
  logic [INPUTBITWIDTH-1:0]   isolated;   // one-hot lowest set bit (or 0)
  logic [INPUTBITWIDTH-1:0]   remainder;  // pending with lowest bit cleared
  logic [OUTPUTBITWIDTH-1:0]  index_enc;

  // Two's complement trick: x & -x keeps only the lowest set bit,
  // x & (x-1) clears it.
  assign isolated  = pending_reg & (~pending_reg + ONE);
  assign remainder = pending_reg & (pending_reg - ONE);

  // One-hot to binary: index bit b is set when the isolated bit sits at a
  // position whose binary value has bit b set. Because `isolated` is one-hot,
  // an OR over those positions is an exact encoder with no priority chain.
  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTBITWIDTH; gi++) begin : g_index_bit
      logic [INPUTBITWIDTH-1:0] sel_mask;

      always_comb begin
        sel_mask = '0;
        for (int j = 0; j < INPUTBITWIDTH; j++) begin
          sel_mask[j] = (((j >> gi) & 1) == 1);
        end
      end

      assign index_enc[gi] = |(isolated & sel_mask);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output decode: everything except in_ready comes from registers only
  // ---------------------------------------------------------------------------
  logic in_run;
  logic in_null;
  logic beat_done;
  logic last_done;
  logic accept;

  assign in_run = (state_reg == RUN);

`ifdef SET_BIT_SEQUENCER_NULL_EN
  assign in_null = (state_reg == NULL_BEAT);
`else
  assign in_null = 1'b0;
`endif

  assign out_valid = in_run | in_null;
  // In NULL_BEAT pending is zero, so remainder is zero and out_last is 1.
  assign out_last  = out_valid & (remainder == '0);
  assign out_index = in_run ? index_enc : '0;
  assign out_null  = in_null;
  assign busy      = (state_reg != IDLE);

  assign beat_done = out_valid & out_ready;
  assign last_done = beat_done & out_last;

  // A new vector is taken either when idle or in the cycle the final beat
  // of the current vector is consumed, which gives back-to-back streaming.
  // A flush cycle refuses input so nothing is loaded and then discarded.
  assign in_ready = ~flush & ((state_reg == IDLE) | last_done);
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;

    case (state_reg)
      IDLE: begin
        // Waits for a vector; loading is handled below.
      end

      RUN: begin
        if (out_ready) begin
          pending_next = remainder;
          if (out_last) begin
            state_next = IDLE;
          end
        end
      end

`ifdef SET_BIT_SEQUENCER_NULL_EN
      NULL_BEAT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
`endif

      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase

    // Load covers both the IDLE case and the last-beat overlap from a
    // running state; it overrides the retire above.
    if (accept) begin
      pending_next = in_data;
      state_next   = (|in_data) ? RUN : EMPTY_STATE;
    end

    // Flush wins over everything, including a beat handshake in this cycle.
    if (flush) begin
      state_next   = IDLE;
      pending_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

endmodule
